// File: rtl/wb_trace_fifo_pkg.sv
// rtl/wb_trace_fifo_pkg.sv - trace record layout and writeback qualify rule
package wb_trace_fifo_pkg;

   localparam int TRACE_REC_WD = 73;

   // Field order is consumed by the trace comparator: {pc, wen, wnum, wdata}.
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_rec_t;

   function automatic logic qualify(input logic [3:0] wen, input logic [4:0] wnum,
                                    input logic filter_r0);
      return (|wen) && !(filter_r0 && (wnum == 5'd0));
   endfunction

endpackage

// File: rtl/wb_trace_fifo_sync_fifo_fwft.sv
// rtl/wb_trace_fifo_sync_fifo_fwft.sv - generic first-word-fall-through register FIFO
module sync_fifo_fwft #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop && !empty && !clear;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign wr_en = push && (!full || rd_en) && !clear;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - buffers CPU writeback retirements as trace records
import wb_trace_fifo_pkg::*;

module wb_trace_fifo #(
   parameter int DEPTH     = 16,
   parameter bit FILTER_R0 = 1'b1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [31:0]               wb_pc,
   input  logic [3:0]                wb_rf_wen,
   input  logic [4:0]                wb_rf_wnum,
   input  logic [31:0]               wb_rf_wdata,
   input  logic                      clear,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [TRACE_REC_WD-1:0]   trace_rec,
   output logic [$clog2(DEPTH):0]    trace_count,
   output logic                      trace_overflow,
   output logic [31:0]               retire_cnt
);

   trace_rec_t rec_in;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;

   assign rec_in      = '{pc: wb_pc, wen: wb_rf_wen, wnum: wb_rf_wnum, wdata: wb_rf_wdata};
   assign push        = qualify(wb_rf_wen, wb_rf_wnum, FILTER_R0) && !clear;
   assign trace_valid = !empty;
   assign pop         = trace_valid && trace_ready && !clear;

   sync_fifo_fwft #(
      .WIDTH(TRACE_REC_WD),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (rec_in),
      .rdata (trace_rec),
      .count (trace_count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         trace_overflow <= 1'b0;
         retire_cnt     <= '0;
      end else if (clear) begin
         trace_overflow <= 1'b0;
         retire_cnt     <= '0;
      end else begin
         if (push && full && !pop) trace_overflow <= 1'b1;
         if (push) retire_cnt <= retire_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - randomized scoreboard bench for wb_trace_fifo
module tb_wb_trace_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] wb_pc = '0;
   logic [3:0]  wb_rf_wen = '0;
   logic [4:0]  wb_rf_wnum = '0;
   logic [31:0] wb_rf_wdata = '0;
   logic        clear = 1'b0;
   logic        trace_ready = 1'b0;
   logic        trace_valid;
   logic [72:0] trace_rec;
   logic [4:0]  trace_count;
   logic        trace_overflow;
   logic [31:0] retire_cnt;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   logic [72:0] mq[$];
   bit          m_ovf = 1'b0;
   logic [31:0] m_ret = '0;

   wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) dut (
      .clk(clk), .resetn(resetn), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen),
      .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata), .clear(clear),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_rec(trace_rec),
      .trace_count(trace_count), .trace_overflow(trace_overflow), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of records with the drop/overflow rule applied.
   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         mq.delete();
         m_ovf = 1'b0;
         m_ret = '0;
      end else if (clear) begin
         mq.delete();
         m_ovf = 1'b0;
         m_ret = '0;
      end else begin
         bit do_push;
         do_push = (wb_rf_wen != 4'h0) && (wb_rf_wnum != 5'd0);
         if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
         if (do_push) begin
            m_ret = m_ret + 32'd1;
            if (mq.size() < DEPTH) mq.push_back({wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata});
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", 73'(trace_valid), 73'(mq.size() != 0));
         chk("count", 73'(trace_count), 73'(mq.size()));
         chk("overflow", 73'(trace_overflow), 73'(m_ovf));
         chk("retire_cnt", 73'(retire_cnt), 73'(m_ret));
         if (mq.size() != 0) chk("rec", trace_rec, mq[0]);
      end
   end

   task automatic drive(input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] pc,
                        input logic [31:0] wd, input logic rdy, input logic clr);
      @(negedge clk);
      wb_rf_wen = wen; wb_rf_wnum = wnum; wb_pc = pc; wb_rf_wdata = wd;
      trace_ready = rdy; clear = clr;
   endtask

   task automatic idle(input logic rdy);
      drive(4'h0, 5'd0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   logic [72:0] exp_recs [17];

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", 73'(trace_valid), 73'(0));
      chk("rst_count", 73'(trace_count), 73'(0));
      chk("rst_overflow", 73'(trace_overflow), 73'(0));
      chk("rst_retire", 73'(retire_cnt), 73'(0));
      resetn = 1'b1;
      chk_en = 1'b1;

      // Single writeback, visible one cycle later
      drive(4'hf, 5'd3, 32'h1c000000, 32'h12345678, 1'b0, 1'b0);
      idle(1'b0);
      chk("t1_valid", 73'(trace_valid), 73'(1));
      chk("t1_rec", trace_rec, {32'h1c000000, 4'hf, 5'd3, 32'h12345678});
      chk("t1_count", 73'(trace_count), 73'(1));
      chk("t1_retire", 73'(retire_cnt), 73'(1));

      // Filtered writebacks: wnum==0 and wen==0
      drive(4'hf, 5'd0, 32'h1c000004, 32'hdeadbeef, 1'b0, 1'b0);
      drive(4'h0, 5'd5, 32'h1c000008, 32'hcafef00d, 1'b0, 1'b0);
      idle(1'b0);
      chk("t2_count", 73'(trace_count), 73'(1));
      chk("t2_retire", 73'(retire_cnt), 73'(1));

      // 17 pushes into a stalled FIFO
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 17; i++) begin
         exp_recs[i] = {32'h1c001000 + 32'(i*4), 4'h3, 5'(i + 1), 32'ha5000000 + 32'(i)};
         drive(4'h3, 5'(i + 1), 32'h1c001000 + 32'(i*4), 32'ha5000000 + 32'(i), 1'b0, 1'b0);
      end
      idle(1'b0);
      chk("t3_count", 73'(trace_count), 73'(16));
      chk("t3_overflow", 73'(trace_overflow), 73'(1));
      chk("t3_retire", 73'(retire_cnt), 73'(17));
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("t3_drain", trace_rec, exp_recs[i]);
         trace_ready = 1'b1;
      end
      @(negedge clk);
      chk("t3_empty", 73'(trace_valid), 73'(0));
      trace_ready = 1'b0;

      // Full FIFO with simultaneous push and pop
      drive(4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++)
         drive(4'hf, 5'd7, 32'h1c002000 + 32'(i*4), $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         drive(4'hf, 5'd9, 32'h1c003000 + 32'(i*4), $urandom, 1'b1, 1'b0);
      idle(1'b0);
      chk("t4_count", 73'(trace_count), 73'(16));
      chk("t4_overflow", 73'(trace_overflow), 73'(0));
      chk("t4_retire", 73'(retire_cnt), 73'(36));

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         logic [3:0] w;
         w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         drive(w, 5'($urandom), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 999) == 0));
      end

      // Asynchronous reset between edges
      for (int i = 0; i < 5; i++) drive(4'hf, 5'd4, 32'h1c004000, $urandom, 1'b0, 1'b0);
      idle(1'b0);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_valid", 73'(trace_valid), 73'(0));
      chk("async_count", 73'(trace_count), 73'(0));
      @(negedge clk);
      resetn = 1'b1;

      // Clear together with a push
      for (int i = 0; i < 3; i++) drive(4'hf, 5'd6, 32'h1c005000, $urandom, 1'b0, 1'b0);
      drive(4'hf, 5'd6, 32'h1c005010, 32'h11111111, 1'b0, 1'b1);
      idle(1'b0);
      chk("clr_count", 73'(trace_count), 73'(0));
      chk("clr_retire", 73'(retire_cnt), 73'(0));
      chk("clr_valid", 73'(trace_valid), 73'(0));
      idle(1'b0);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
